// File: rtl/emu_sat_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : emu_sat_combiner
//  Description : Combines emulated GNSS satellite-channel beats into one
//                complex baseband sample per frame. Each beat's Doppler NCO
//                value is BPSK-modulated by (chip XOR nav), scaled by a
//                per-channel gain, and summed into a saturating accumulator.
//                At the end of a frame the sum is shifted right by SHIFT and
//                saturated to OUT_W bits.
//
//  Ports       : clk        - clock, rising edge
//                resetn     - synchronous active-low reset
//                dv_in      - beat valid
//                first/last - frame delimiters, qualified by dv_in
//                real_in    - signed 6-bit NCO cos
//                imag_in    - signed 6-bit NCO sin
//                chip, nav  - code chip / nav bit (1 = -1)
//                gain       - unsigned 4-bit channel amplitude
//                dv_out     - combined sample valid pulse (beat + 3 clocks)
//                real_out   - signed OUT_W combined real (held)
//                imag_out   - signed OUT_W combined imag (held)
//                frame_err  - framing violation pulse (beat + 2 clocks)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module emu_sat_combiner #(
    parameter int OUT_W = 8,    // must not exceed the 15-bit accumulator width
    parameter int SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    dv_in,
    input  logic                    first,
    input  logic                    last,
    input  logic signed [5:0]       real_in,
    input  logic signed [5:0]       imag_in,
    input  logic                    chip,
    input  logic                    nav,
    input  logic        [3:0]       gain,
    output logic                    dv_out,
    output logic signed [OUT_W-1:0] real_out,
    output logic signed [OUT_W-1:0] imag_out,
    output logic                    frame_err
);

    // Accumulator limits, expressed both at accumulator width and at the
    // one-bit-wider width used for the pre-clamp sum.
    localparam logic signed [14:0] c_ACC_MAX = 15'sh3FFF;    // +16383
    localparam logic signed [14:0] c_ACC_MIN = 15'sh4000;    // -16384
    localparam logic signed [15:0] c_SUM_MAX = 16'sh3FFF;
    localparam logic signed [15:0] c_SUM_MIN = 16'shC000;

    // Output limits at accumulator width (for comparison) and at OUT_W.
    localparam logic signed [14:0]      c_OUT_MAX15 = 15'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [14:0]      c_OUT_MIN15 = 15'(-(2 ** (OUT_W - 1)));
    localparam logic signed [OUT_W-1:0] c_OUT_MAX   = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_OUT_MIN   = {1'b1, {(OUT_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic signed [14:0] sat_add(
        input logic signed [14:0] acc,
        input logic signed [10:0] prod
    );
        logic signed [15:0] sum;
        sum = {acc[14], acc} + {{5{prod[10]}}, prod};
        if (sum > c_SUM_MAX)
            sat_add = c_ACC_MAX;
        else if (sum < c_SUM_MIN)
            sat_add = c_ACC_MIN;
        else
            sat_add = sum[14:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(
        input logic signed [14:0] acc
    );
        logic signed [14:0] sh;
        sh = acc >>> SHIFT;
        if (sh > c_OUT_MAX15)
            sat_out = c_OUT_MAX;
        else if (sh < c_OUT_MIN15)
            sat_out = c_OUT_MIN;
        else
            sat_out = sh[OUT_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Stage 0 (combinational): modulation and gain
    // ------------------------------------------------------------------
    // Widening to 7 bits before negation lets -(-32) become +32 cleanly.
    logic               w_neg;
    logic signed [6:0]  w_re7;
    logic signed [6:0]  w_im7;
    logic signed [6:0]  w_mod_re;
    logic signed [6:0]  w_mod_im;
    logic signed [10:0] w_gain_x;
    logic signed [10:0] w_prod_re;
    logic signed [10:0] w_prod_im;

    assign w_neg    = chip ^ nav;
    assign w_re7    = {real_in[5], real_in};
    assign w_im7    = {imag_in[5], imag_in};
    assign w_mod_re = w_neg ? -w_re7 : w_re7;
    assign w_mod_im = w_neg ? -w_im7 : w_im7;
    assign w_gain_x = $signed({7'b0, gain});
    // |product| <= 32*15 = 480, so an 11-bit result is exact.
    assign w_prod_re = {{4{w_mod_re[6]}}, w_mod_re} * w_gain_x;
    assign w_prod_im = {{4{w_mod_im[6]}}, w_mod_im} * w_gain_x;

    // ------------------------------------------------------------------
    // Stage 1: register product and beat qualifiers
    // ------------------------------------------------------------------
    logic               r_s1_dv;
    logic               r_s1_first;
    logic               r_s1_last;
    logic signed [10:0] r_s1_re;
    logic signed [10:0] r_s1_im;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_dv    <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
        end else begin
            r_s1_dv    <= dv_in;
            r_s1_first <= first;
            r_s1_last  <= last;
            r_s1_re    <= w_prod_re;
            r_s1_im    <= w_prod_im;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: frame tracking and accumulation
    // ------------------------------------------------------------------
    logic               r_open;
    logic signed [14:0] r_acc_re;
    logic signed [14:0] r_acc_im;
    logic               r_s2_fire;
    logic               r_s2_err;

    logic               w_open_nxt;
    logic signed [14:0] w_acc_re_nxt;
    logic signed [14:0] w_acc_im_nxt;
    logic               w_fire_nxt;
    logic               w_err_nxt;

    always_comb begin
        w_open_nxt   = r_open;
        w_acc_re_nxt = r_acc_re;
        w_acc_im_nxt = r_acc_im;
        w_fire_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        if (r_s1_dv) begin
            if (r_s1_first) begin
                // A first beat always (re)starts a frame; flag it if it
                // truncated one that was still open.
                w_err_nxt    = r_open;
                w_acc_re_nxt = {{4{r_s1_re[10]}}, r_s1_re};
                w_acc_im_nxt = {{4{r_s1_im[10]}}, r_s1_im};
                w_open_nxt   = ~r_s1_last;
                w_fire_nxt   = r_s1_last;
            end else if (r_open) begin
                w_acc_re_nxt = sat_add(r_acc_re, r_s1_re);
                w_acc_im_nxt = sat_add(r_acc_im, r_s1_im);
                w_open_nxt   = ~r_s1_last;
                w_fire_nxt   = r_s1_last;
            end else begin
                // Orphan beat: dropped without touching the accumulator.
                w_err_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_open    <= 1'b0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_s2_fire <= 1'b0;
            r_s2_err  <= 1'b0;
        end else begin
            r_open    <= w_open_nxt;
            r_acc_re  <= w_acc_re_nxt;
            r_acc_im  <= w_acc_im_nxt;
            r_s2_fire <= w_fire_nxt;
            r_s2_err  <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: scale and saturate completed frames
    // ------------------------------------------------------------------
    logic                    r_dv_out;
    logic signed [OUT_W-1:0] r_real_out;
    logic signed [OUT_W-1:0] r_imag_out;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dv_out   <= 1'b0;
            r_real_out <= '0;
            r_imag_out <= '0;
        end else begin
            r_dv_out <= r_s2_fire;
            if (r_s2_fire) begin
                r_real_out <= sat_out(r_acc_re);
                r_imag_out <= sat_out(r_acc_im);
            end
        end
    end

    assign dv_out    = r_dv_out;
    assign real_out  = r_real_out;
    assign imag_out  = r_imag_out;
    assign frame_err = r_s2_err;

endmodule
`default_nettype wire

// File: doc/emu_sat_combiner.md
EMU_SAT_COMBINER -- requirements
Module: emu_sat_combiner

Interface
REQ-001 Parameter OUT_W, default 8, width of the signed combined real/imag outputs.
REQ-002 Parameter SHIFT, default 2, arithmetic right shift applied to the accumulator before saturation.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 dv_in  input  1  one satellite-channel beat valid this cycle.
REQ-006 first  input  1  beat is the first channel of a sample frame; qualified by dv_in.
REQ-007 last  input  1  beat is the last channel of a sample frame; qualified by dv_in.
REQ-008 real_in  input  6  signed two's-complement Doppler NCO real (cos) output.
REQ-009 imag_in  input  6  signed two's-complement Doppler NCO imag (sin) output.
REQ-010 chip  input  1  C/A code chip: 0 = +1, 1 = -1.
REQ-011 nav  input  1  navigation data bit: 0 = +1, 1 = -1.
REQ-012 gain  input  4  unsigned per-channel amplitude, 0..15.
REQ-013 dv_out  output  1  one-cycle pulse, combined sample valid.
REQ-014 real_out  output  OUT_W  signed combined real sample.
REQ-015 imag_out  output  OUT_W  signed combined imag sample.
REQ-016 frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-017 Each dv_in beat is modulated by s = chip XOR nav; s=1 negates real_in and imag_in; negation uses 7-bit signed arithmetic, so -(-32) = +32 and no wrap occurs.
REQ-018 The modulated value is multiplied by gain into an 11-bit signed product, range -480..+480, which is exact.
REQ-019 Stage 1 registers the product, first, last and dv_in 1 cycle after the input beat.
REQ-020 Stage 2 accumulates into a 15-bit signed accumulator per component: a first beat loads the product; any other beat adds it.
REQ-021 The accumulator saturates at +16383 and -16384 and never wraps.
REQ-022 A frame is open from a first beat through the following last beat; first and last on the same beat form a one-channel frame.
REQ-023 Cycles with dv_in=0 are ignored, the accumulator holds, and an open frame stays open for any number of idle cycles.
REQ-024 On a last beat, stage 3 computes the accumulator value including that beat, arithmetic-shifts it right by SHIFT, and saturates it to the OUT_W signed range.
REQ-025 dv_out pulses exactly 3 clocks after the input beat carrying last; real_out and imag_out hold their value until the next dv_out.
REQ-026 A first beat while a frame is already open pulses frame_err; the accumulator reloads and the new frame proceeds.
REQ-027 A non-first beat while no frame is open pulses frame_err and is discarded with no accumulation and no dv_out, including when that beat carries last.
REQ-028 frame_err is aligned with the stage-2 update, 2 clocks after the offending beat.
REQ-029 Back-to-back frames at full rate (last followed by first on the next cycle) are supported with no bubbles.
REQ-030 The block has no backpressure; one beat is accepted every cycle that dv_in is high.

Reset
REQ-031 While resetn=0 at a clock edge: dv_out=0, frame_err=0, real_out=0, imag_out=0, accumulators=0, frame closed, all pipeline valids cleared.
REQ-032 Reset mid-frame discards the partial frame; no dv_out or frame_err results from beats accepted before the reset.
REQ-033 The first beat after resetn returns high is accepted in that same cycle.

Verification
REQ-034 Single one-channel frame: first=last=1, real_in=10, imag_in=-5, chip=0, nav=0, gain=4 -> dv_out 3 clocks later; real_out=10, imag_out=-5 (40>>2, -20>>2).
REQ-035 Four-channel frame with gain=15, real_in=31, s=0 on every beat, and a 3-cycle dv_in gap between beats 2 and 3 -> one dv_out; real_out=sat(1860>>2=465)=+127.
REQ-036 Modulation: chip=1, nav=0, real_in=-32, gain=1, SHIFT=0 -> real_out=+32; chip=1, nav=1 on the same data -> real_out=-32.
REQ-037 Accumulator saturation: 40 beats of product -480 in one frame -> accumulator pinned at -16384; real_out=-128.
REQ-038 Framing errors: a last beat with no open frame -> frame_err pulse and no dv_out; first, first, last -> one frame_err and one dv_out containing only the second frame.
REQ-039 Reset mid-frame after two beats, then a clean one-channel frame -> no output for the aborted frame; the clean frame's output is correct, with dv_out 3 clocks after its beat.
